// File: rtl/os_integ_ctrl.sv
// Offset integrator: accumulates 16..128 signed X/Y sample pairs through one shared adder, 3 cycles per sample.
// Optional macro OS_INTEG_SAT_EN clamps each addition to the signed ACC_W range; without it additions wrap.
module os_integ_ctrl #(
  parameter int OS_W  = 6,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       speed_sel,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [OS_W-1:0]  x_os,
  input  logic [OS_W-1:0]  y_os,
  output logic             sample_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] x_res,
  output logic [ACC_W-1:0] y_res,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ACCUM, ADD_X, ADD_Y, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_period;
  logic [7:0]       r_cnt;
  logic [ACC_W-1:0] r_acc_x;
  logic [ACC_W-1:0] r_acc_y;
  logic [OS_W-1:0]  r_x;
  logic [OS_W-1:0]  r_y;
  logic [ACC_W-1:0] r_x_res;
  logic [ACC_W-1:0] r_y_res;

  logic             w_clear;
  logic [7:0]       w_period_sel;
  logic [7:0]       w_cnt_inc;
  logic             w_last;
  logic [OS_W-1:0]  w_smp;
  logic [ACC_W-1:0] w_add_a;
  logic [ACC_W-1:0] w_add_b;
  logic [ACC_W-1:0] w_raw;
  logic [ACC_W-1:0] w_sum;

  assign w_period_sel = 8'd16 << speed_sel;
  assign w_cnt_inc    = r_cnt + 8'd1;
  assign w_last       = (w_cnt_inc == r_period);

  // The single adder serves X in ADD_X and Y in ADD_Y.
  assign w_add_a = (r_state == ADD_Y) ? r_acc_y : r_acc_x;
  assign w_smp   = (r_state == ADD_Y) ? r_y : r_x;
  assign w_add_b = {{(ACC_W-OS_W){w_smp[OS_W-1]}}, w_smp};
  assign w_raw   = w_add_a + w_add_b;

`ifdef OS_INTEG_SAT_EN
  logic w_ovf;
  assign w_ovf = (w_add_a[ACC_W-1] == w_add_b[ACC_W-1]) && (w_raw[ACC_W-1] != w_add_a[ACC_W-1]);
  assign w_sum = !w_ovf ? w_raw :
                 w_add_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_sum = w_raw;
`endif

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next  = ACCUM;
          w_clear = 1'b1;
        end
      end
      ACCUM: begin
        if (sample_valid) w_next = ADD_X;
      end
      ADD_X: w_next = ADD_Y;
      ADD_Y: w_next = w_last ? DONE : ACCUM;
      DONE: begin
        if (res_ready) begin
          w_next  = start ? ACCUM : IDLE;
          w_clear = start;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_cnt    <= '0;
      r_acc_x  <= '0;
      r_acc_y  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_x_res  <= '0;
      r_y_res  <= '0;
    end else begin
      if (w_clear) begin
        r_period <= w_period_sel;
        r_cnt    <= '0;
        r_acc_x  <= '0;
        r_acc_y  <= '0;
      end
      case (r_state)
        ACCUM: begin
          if (sample_valid) begin
            r_x <= x_os;
            r_y <= y_os;
          end
        end
        ADD_X: r_acc_x <= w_sum;
        ADD_Y: begin
          r_acc_y <= w_sum;
          r_cnt   <= w_cnt_inc;
          // Y result comes straight off the adder so it lands together with X.
          if (w_last) begin
            r_x_res <= r_acc_x;
            r_y_res <= w_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign sample_ready = (r_state == ACCUM);
  assign res_valid    = (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign x_res        = r_x_res;
  assign y_res        = r_y_res;

endmodule

// File: tb/tb_os_integ_ctrl.sv
// Bench for os_integ_ctrl: directed and randomized integration runs against an integer-sum reference model.
module tb_os_integ_ctrl;
  localparam int OS_W  = 6;
  localparam int ACC_W = 12;

  logic             clk;
  logic             rst_n;
  logic [1:0]       speed_sel;
  logic             start;
  logic             sample_valid;
  logic [OS_W-1:0]  x_os;
  logic [OS_W-1:0]  y_os;
  logic             sample_ready;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] x_res;
  logic [ACC_W-1:0] y_res;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  os_integ_ctrl #(.OS_W(OS_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .speed_sel(speed_sel), .start(start),
    .sample_valid(sample_valid), .x_os(x_os), .y_os(y_os),
    .sample_ready(sample_ready), .res_valid(res_valid), .res_ready(res_ready),
    .x_res(x_res), .y_res(y_res), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: running integer sum, clamped per addition when saturation is built in.
  function automatic int model_add(input int acc, input logic [OS_W-1:0] s);
    int r;
    r = acc + int'($signed(s));
`ifdef OS_INTEG_SAT_EN
    if (r > 2047)  r = 2047;
    if (r < -2048) r = -2048;
`endif
    return r;
  endfunction

  task automatic run(input logic [1:0] spd, input bit rnd, input logic [OS_W-1:0] xc,
                     input logic [OS_W-1:0] yc, input int n_feed, input int hold,
                     input bit chain, input logic [1:0] chain_spd, input bit skip_start);
    int period;
    int ax;
    int ay;
    int waitc;
    int gap;
    int lat;
    logic [OS_W-1:0]  xs;
    logic [OS_W-1:0]  ys;
    logic [ACC_W-1:0] ex;
    logic [ACC_W-1:0] ey;
    logic [ACC_W-1:0] old_x;
    logic [ACC_W-1:0] old_y;
    period = 16 * (1 << spd);
    ax = 0;
    ay = 0;
    if (!skip_start) begin
      @(negedge clk);
      speed_sel = spd;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1);
    end
    speed_sel = 2'($urandom);
    for (int n = 0; n < n_feed; n++) begin
      waitc = 0;
      while (!sample_ready && waitc < 8) begin
        @(negedge clk);
        waitc++;
      end
      check("ready_wait", sample_ready, 1);
      if (rnd) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          start = 1'($urandom);
          @(negedge clk);
        end
        start = 1'b0;
      end
      xs = rnd ? OS_W'($urandom) : xc;
      ys = rnd ? OS_W'($urandom) : yc;
      sample_valid = 1'b1;
      x_os = xs;
      y_os = ys;
      @(negedge clk);
      sample_valid = 1'b0;
      x_os = OS_W'($urandom);
      y_os = OS_W'($urandom);
      ax = model_add(ax, xs);
      ay = model_add(ay, ys);
      if (n == 0) check("ready_low_add", sample_ready, 0);
    end
    if (n_feed < period) return;
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("res_latency", lat, 3);
    ex = ax[ACC_W-1:0];
    ey = ay[ACC_W-1:0];
    check("x_res", x_res, ex);
    check("y_res", y_res, ey);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_x", x_res, ex);
      check("hold_y", y_res, ey);
      check("hold_ready", sample_ready, 0);
    end
    res_ready = 1'b1;
    if (chain) begin
      start = 1'b1;
      speed_sel = chain_spd;
    end
    old_x = x_res;
    old_y = y_res;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_busy", busy, chain);
    check("post_accum", sample_ready, chain);
    check("post_x_keep", x_res, old_x);
    check("post_y_keep", y_res, old_y);
  endtask

  initial begin
    rst_n = 1'b0;
    speed_sel = 2'd0;
    start = 1'b1;
    sample_valid = 1'b0;
    x_os = '0;
    y_os = '0;
    res_ready = 1'b0;
    #12;
    check("rst_ready", sample_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_x", x_res, 0);
    check("rst_y", y_res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("no_early_leave", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("first_edge_start", busy, 1);
    run(2'd0, 1'b0, 6'h01, 6'h3F, 16, 10, 1'b0, 2'd0, 1'b1);
    check("r033_x", x_res, 12'h010);
    check("r033_y", y_res, 12'hFF0);

    run(2'd3, 1'b0, 6'h1F, 6'h00, 128, 0, 1'b0, 2'd0, 1'b0);
`ifdef OS_INTEG_SAT_EN
    check("r034_x", x_res, 12'h7FF);
`else
    check("r034_x", x_res, 12'hF80);
`endif
    run(2'd3, 1'b0, 6'h00, 6'h20, 128, 0, 1'b0, 2'd0, 1'b0);
`ifdef OS_INTEG_SAT_EN
    check("r035_y", y_res, 12'h800);
`else
    check("r035_y", y_res, 12'h000);
`endif

    run(2'd1, 1'b1, 6'h00, 6'h00, 32, 2, 1'b1, 2'd0, 1'b0);
    run(2'd0, 1'b1, 6'h00, 6'h00, 16, 1, 1'b1, 2'd2, 1'b1);
    run(2'd2, 1'b1, 6'h00, 6'h00, 64, 0, 1'b0, 2'd0, 1'b1);
    run(2'd0, 1'b1, 6'h00, 6'h00, 16, 0, 1'b0, 2'd0, 1'b0);

    run(2'd0, 1'b1, 6'h00, 6'h00, 7, 0, 1'b0, 2'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", sample_ready, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x", x_res, 0);
    check("mid_rst_y", y_res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2'd0, 1'b0, 6'h02, 6'h05, 16, 0, 1'b0, 2'd0, 1'b0);
    check("after_rst_x", x_res, 12'h020);
    check("after_rst_y", y_res, 12'h050);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/os_integ_ctrl.md
OS_INTEG_CTRL -- requirements
Module: os_integ_ctrl

Interface
REQ-001 SHALL have parameter OS_W, default 6, which is the signed offset sample width.
REQ-002 SHALL have parameter ACC_W, default 12, which is the integrator and result width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port speed_sel, input, 2 bits: integration period select (0:16, 1:32, 2:64, 3:128 samples).
REQ-006 SHALL have port start, input, 1 bit: begins an integration run.
REQ-007 SHALL have port sample_valid, input, 1 bit: x_os/y_os carry a sample pair.
REQ-008 SHALL have port x_os, input, OS_W bits: X offset sample, two's complement.
REQ-009 SHALL have port y_os, input, OS_W bits: Y offset sample, two's complement.
REQ-010 SHALL have port sample_ready, output, 1 bit: the block accepts a sample pair this cycle.
REQ-011 SHALL have port res_valid, output, 1 bit: x_res/y_res hold a completed integration.
REQ-012 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port x_res, output, ACC_W bits: integrated X result.
REQ-014 SHALL have port y_res, output, ACC_W bits: integrated Y result.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, ADD_X, ADD_Y, DONE.
REQ-017 SHALL, in IDLE with start=1, clear acc_x/acc_y and the sample counter, latch the period from speed_sel, and go to ACCUM.
REQ-018 SHALL ignore start outside IDLE and DONE; speed_sel changes mid-run SHALL have no effect.
REQ-019 SHALL drive sample_ready=1 only in ACCUM; on sample_valid&sample_ready, register x_os/y_os and go to ADD_X.
REQ-020 SHALL use exactly one ACC_W-bit adder, shared: ADD_X computes acc_x + sext(x); ADD_Y computes acc_y + sext(y) and increments the counter.
REQ-021 SHALL sign-extend samples by replicating bit OS_W-1 up to ACC_W bits.
REQ-022 SHALL leave ADD_Y for DONE when the counter reaches the latched period, else for ACCUM; each sample occupies 3 cycles minimum.
REQ-023 SHALL load x_res/y_res from the final acc_x/acc_y on the ADD_Y->DONE transition, so that res_valid rises 3 cycles after the last sample is accepted.
REQ-024 SHALL hold res_valid, x_res and y_res stable in DONE until res_ready=1.
REQ-025 SHALL, in DONE with res_ready=1, go to IDLE, or to ACCUM with the clear and latch of REQ-017 if start=1 in the same cycle.
REQ-026 SHALL keep x_res/y_res holding their last loaded values outside DONE, with res_valid=0.
REQ-027 SHALL wrap additions modulo 2^ACC_W when OS_INTEG_SAT_EN is undefined.

Reset
REQ-028 SHALL, on rst_n=0 at any time (including mid-run), immediately force state IDLE and set acc_x, acc_y, counter, x_res and y_res to 0.
REQ-029 SHALL, during reset, drive sample_ready=0, res_valid=0 and busy=0.
REQ-030 SHALL leave IDLE no earlier than the first clk edge after rst_n rises.

Configuration
REQ-031 SHALL, when the macro OS_INTEG_SAT_EN is defined, clamp each addition to the signed ACC_W range (max 0x7FF, min 0x800 at ACC_W=12).
REQ-032 SHALL, when OS_INTEG_SAT_EN is undefined, wrap per REQ-027 and include no clamp logic.

Verification
REQ-033 SHALL cover: speed_sel=0, x_os=0x01, y_os=0x3F on 16 samples -> x_res=0x010, y_res=0xFF0, res_valid 3 cycles after the 16th accept.
REQ-034 SHALL cover: speed_sel=3, x_os=0x1F on 128 samples -> x_res=0xF80 without the macro, 0x7FF with it.
REQ-035 SHALL cover: speed_sel=3, y_os=0x20 on 128 samples -> y_res=0x000 without the macro, 0x800 with it.
REQ-036 SHALL cover: res_ready held 0 for 10 cycles in DONE -> res_valid, x_res and y_res stable; sample_ready=0 throughout.
REQ-037 SHALL cover: start and res_ready both 1 in DONE -> the next cycle is ACCUM with cleared accumulators, and the old x_res is retained until the next load.
REQ-038 SHALL cover: rst_n pulsed low at sample 7 of 16 -> all outputs 0 and state IDLE asynchronously; a new start then yields the full 16-sample result.
